mul_div_unit: RTL and testbench



---
 rtl/mdu_pkg.sv | 29 ++
 rtl/mdu_datapath.sv | 105 ++++++++++
 rtl/mul_div_unit.sv | 141 ++++++++++++++
 tb/tb_mul_div_unit.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op and state encodings,
// default widths and small op-decoding helpers.
package mdu_pkg;

    localparam int unsigned XLEN_DEFAULT  = 32;
    localparam int unsigned CNT_W_DEFAULT = 6;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        FIX  = 2'b10
    } state_e;

    function automatic logic op_is_signed(input op_e o);
        return (o == OP_MULT) || (o == OP_DIV);
    endfunction

    function automatic logic op_is_div(input op_e o);
        return (o == OP_DIV) || (o == OP_DIVU);
    endfunction

endpackage

// File: rtl/mdu_datapath.sv
// Magnitude accumulator for the multiply/divide unit: one shift-add or restoring
// shift-subtract step per cycle, plus the sign fixup of the final result.
module mdu_datapath
    import mdu_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic            step,
    input  op_e             op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] res_hi_c,
    output logic [XLEN-1:0] res_lo_c,
    output logic            div0_c
);

    localparam int unsigned AW = 2 * XLEN + 1;

    logic [AW-1:0]   acc_q, acc_d;
    logic [XLEN-1:0] opnd_q, opnd_d;
    logic            is_div_q, is_div_d;
    logic            neg_quo_q, neg_quo_d;
    logic            neg_rem_q, neg_rem_d;
    logic            div0_q, div0_d;

    logic            signed_op;
    logic [XLEN-1:0] abs_a, abs_b;
    logic [XLEN:0]   mul_sum;
    logic [AW-1:0]   div_shift;
    logic [XLEN:0]   div_trial;

    // Operand capture and one iteration step; both ops start from acc = {0, |a|}, opnd = |b|
    always_comb begin
        acc_d     = acc_q;
        opnd_d    = opnd_q;
        is_div_d  = is_div_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        div0_d    = div0_q;

        signed_op = op_is_signed(op);
        abs_a     = (signed_op && a[XLEN-1]) ? -a : a;
        abs_b     = (signed_op && b[XLEN-1]) ? -b : b;

        mul_sum   = acc_q[AW-1:XLEN] + {1'b0, (acc_q[0] ? opnd_q : '0)};
        div_shift = {acc_q[AW-2:0], 1'b0};
        div_trial = div_shift[AW-1:XLEN] - {1'b0, opnd_q};

        if (load) begin
            acc_d     = {(XLEN+1)'(0), abs_a};
            opnd_d    = abs_b;
            is_div_d  = op_is_div(op);
            neg_quo_d = signed_op & (a[XLEN-1] ^ b[XLEN-1]);
            neg_rem_d = signed_op & a[XLEN-1];
            div0_d    = op_is_div(op) & (b == '0);
        end else if (step) begin
            if (is_div_q) begin
                // Negative trial result means restore, i.e. keep the shifted remainder
                acc_d = div_trial[XLEN] ? div_shift
                                        : {div_trial, div_shift[XLEN-1:0] | XLEN'(1)};
            end else begin
                acc_d = {1'b0, mul_sum, acc_q[XLEN-1:1]};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q     <= '0;
            opnd_q    <= '0;
            is_div_q  <= 1'b0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            div0_q    <= 1'b0;
        end else begin
            acc_q     <= acc_d;
            opnd_q    <= opnd_d;
            is_div_q  <= is_div_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            div0_q    <= div0_d;
        end
    end

    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo, rem;

    // Two's-complement sign fixup of the magnitude result
    always_comb begin
        prod = acc_q[2*XLEN-1:0];
        quo  = acc_q[XLEN-1:0];
        rem  = acc_q[2*XLEN-1:XLEN];
        if (is_div_q) begin
            res_lo_c = neg_quo_q ? -quo : quo;
            res_hi_c = neg_rem_q ? -rem : rem;
        end else begin
            {res_hi_c, res_lo_c} = neg_quo_q ? -prod : prod;
        end
        div0_c = div0_q;
    end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative MIPS MULT/MULTU/DIV/DIVU unit with architectural HI/LO and MTHI/MTLO writes.
// Define MUL_DIV_DIV0_FLAG_EN to add a div0 flag and leave HI/LO untouched on divide by zero.
module mul_div_unit
    import mdu_pkg::*;
#(
    parameter int unsigned XLEN  = XLEN_DEFAULT,
    parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            hi_we,
    input  logic            lo_we,
    input  logic [XLEN-1:0] wd,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
`ifdef MUL_DIV_DIV0_FLAG_EN
    ,
    output logic            div0
`endif
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [XLEN-1:0]  hi_q, hi_d;
    logic [XLEN-1:0]  lo_q, lo_d;
`ifdef MUL_DIV_DIV0_FLAG_EN
    logic             div0_q, div0_d;
`endif

    logic             load_c, step_c;
    logic [XLEN-1:0]  dp_hi_c, dp_lo_c;
    logic             dp_div0_c;

    mdu_datapath #(
        .XLEN (XLEN)
    ) u_datapath (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load_c),
        .step     (step_c),
        .op       (op_e'(op)),
        .a        (a),
        .b        (b),
        .res_hi_c (dp_hi_c),
        .res_lo_c (dp_lo_c),
        .div0_c   (dp_div0_c)
    );

    // Next-state, counter and HI/LO write selection
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        hi_d    = hi_q;
        lo_d    = lo_q;
        load_c  = 1'b0;
        step_c  = 1'b0;
`ifdef MUL_DIV_DIV0_FLAG_EN
        div0_d  = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (hi_we) hi_d = wd;
                if (lo_we) lo_d = wd;
                if (start) begin
                    load_c  = 1'b1;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                step_c = 1'b1;
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(XLEN - 1)) state_d = FIX;
            end
            FIX: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
`ifdef MUL_DIV_DIV0_FLAG_EN
                div0_d  = dp_div0_c;
                if (!dp_div0_c) begin
                    hi_d = dp_hi_c;
                    lo_d = dp_lo_c;
                end
`else
                // A zero divisor yields an all-ones quotient regardless of operand signs
                hi_d = dp_hi_c;
                lo_d = dp_div0_c ? '1 : dp_lo_c;
`endif
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
`ifdef MUL_DIV_DIV0_FLAG_EN
            div0_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
`ifdef MUL_DIV_DIV0_FLAG_EN
            div0_q  <= div0_d;
`endif
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;
`ifdef MUL_DIV_DIV0_FLAG_EN
    assign div0 = div0_q;
`endif

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: expected HI/LO pushed at issue, popped and compared on done.
module tb_mul_div_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a, b, wd;
    logic        hi_we, lo_we;
    logic        busy, done;
    logic [31:0] hi, lo;
`ifdef MUL_DIV_DIV0_FLAG_EN
    logic        div0;
`endif

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    always #5 clk = ~clk;

    mul_div_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .hi_we (hi_we),
        .lo_we (lo_we),
        .wd    (wd),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
`ifdef MUL_DIV_DIV0_FLAG_EN
        ,
        .div0  (div0)
`endif
    );

    function automatic exp_t model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        exp_t               e;
        logic signed [63:0] sx, sy, p;
        logic [63:0]        u;
        sx   = $signed({{32{x[31]}}, x});
        sy   = $signed({{32{y[31]}}, y});
        e.dz = 1'b0;
        case (o)
            2'b00: begin p = sx * sy; e.hi = p[63:32]; e.lo = p[31:0]; end
            2'b01: begin u = {32'd0, x} * {32'd0, y}; e.hi = u[63:32]; e.lo = u[31:0]; end
            default: begin
                if (y == 32'd0) begin
                    e.dz = 1'b1; e.hi = x; e.lo = 32'hFFFF_FFFF;
                end else if (o == 2'b10) begin
                    e.lo = 32'(sx / sy); e.hi = 32'(sx % sy);
                end else begin
                    e.lo = x / y; e.hi = x % y;
                end
            end
        endcase
        return e;
    endfunction

    // Drive start for one cycle from a negedge; push the expected result if it should be accepted
    task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y, input bit accept);
        exp_t e;
        start = 1'b1; op = o; a = x; b = y;
        if (accept) begin
            e = model(o, x, y);
`ifdef MUL_DIV_DIV0_FLAG_EN
            if (e.dz) begin e.hi = m_hi; e.lo = m_lo; end
`endif
            m_hi = e.hi; m_lo = e.lo;
            exp_q.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (done !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic take(output exp_t e);
        if (exp_q.size() > 0) e = exp_q.pop_front();
        else e = '{hi: 'x, lo: 'x, dz: 1'bx};
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; op = 2'b00; a = '0; b = '0;
        hi_we = 1'b0; lo_we = 1'b0; wd = '0;
        repeat (2) @(negedge clk);
        checks++; if (hi !== 32'd0)  begin errors++; $display("FAIL reset_hi: got %h expected 0", hi); end
        checks++; if (lo !== 32'd0)  begin errors++; $display("FAIL reset_lo: got %h expected 0", lo); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_multu_latency();
        exp_t e; int n, bc;
        issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        n = 0; bc = 0;
        while (done !== 1'b1 && n < 100) begin
            if (busy === 1'b1) bc++;
            @(negedge clk);
            n++;
        end
        take(e);
        checks++; if (n != 33)       begin errors++; $display("FAIL multu_latency: got %0d expected 33", n); end
        checks++; if (bc != 33)      begin errors++; $display("FAIL multu_busy_cycles: got %0d expected 33", bc); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL multu_busy_at_done: got %b expected 0", busy); end
        checks++; if (hi !== e.hi)   begin errors++; $display("FAIL multu_hi: got %h expected %h", hi, e.hi); end
        checks++; if (lo !== e.lo)   begin errors++; $display("FAIL multu_lo: got %h expected %h", lo, e.lo); end
        @(negedge clk);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL done_one_cycle: got %b expected 0", done); end
    endtask

    task automatic test_directed();
        exp_t e; int n;
        logic [1:0]  ops[4] = '{2'b00, 2'b10, 2'b11, 2'b10};
        logic [31:0] as[4]  = '{32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'd5, 32'h8000_0000};
        logic [31:0] bs[4]  = '{32'd3, 32'd2, 32'd0, 32'hFFFF_FFFF};
        for (int i = 0; i < 4; i++) begin
            issue(ops[i], as[i], bs[i], 1'b1);
            wait_done(n);
            take(e);
            checks++; if (n != 33)     begin errors++; $display("FAIL directed%0d_latency: got %0d expected 33", i, n); end
            checks++; if (hi !== e.hi) begin errors++; $display("FAIL directed%0d_hi: got %h expected %h", i, hi, e.hi); end
            checks++; if (lo !== e.lo) begin errors++; $display("FAIL directed%0d_lo: got %h expected %h", i, lo, e.lo); end
`ifdef MUL_DIV_DIV0_FLAG_EN
            checks++; if (div0 !== e.dz) begin errors++; $display("FAIL directed%0d_div0: got %b expected %b", i, div0, e.dz); end
`endif
            @(negedge clk);
        end
    endtask

    task automatic test_mthi_mtlo();
        exp_t e; int n, extra;
        issue(2'b11, 32'd100, 32'd7, 1'b1);
        repeat (3) @(negedge clk);
        hi_we = 1'b1; lo_we = 1'b1; wd = 32'h1234_5678;
        @(negedge clk);
        hi_we = 1'b0; lo_we = 1'b0;
        issue(2'b00, 32'd3, 32'd3, 1'b0);
        wait_done(n);
        take(e);
        checks++; if (hi !== e.hi) begin errors++; $display("FAIL busy_write_hi: got %h expected %h", hi, e.hi); end
        checks++; if (lo !== e.lo) begin errors++; $display("FAIL busy_write_lo: got %h expected %h", lo, e.lo); end
        extra = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done === 1'b1) extra++;
        end
        checks++; if (extra != 0) begin errors++; $display("FAIL ignored_start: got %0d extra done expected 0", extra); end

        hi_we = 1'b1; wd = 32'h1234_5678; m_hi = wd;
        @(negedge clk);
        hi_we = 1'b0; lo_we = 1'b1; wd = 32'hCAFE_F00D; m_lo = wd;
        @(negedge clk);
        lo_we = 1'b0;
        checks++; if (hi !== 32'h1234_5678) begin errors++; $display("FAIL mthi_idle: got %h expected 12345678", hi); end
        checks++; if (lo !== 32'hCAFE_F00D) begin errors++; $display("FAIL mtlo_idle: got %h expected cafef00d", lo); end

        hi_we = 1'b1; wd = 32'hDEAD_BEEF;
        issue(2'b01, 32'd6, 32'd7, 1'b1);
        hi_we = 1'b0;
        checks++; if (hi !== 32'hDEAD_BEEF) begin errors++; $display("FAIL mthi_with_start: got %h expected deadbeef", hi); end
        wait_done(n);
        take(e);
        checks++; if (hi !== e.hi) begin errors++; $display("FAIL mthi_overwrite_hi: got %h expected %h", hi, e.hi); end
        checks++; if (lo !== e.lo) begin errors++; $display("FAIL mthi_overwrite_lo: got %h expected %h", lo, e.lo); end
    endtask

    task automatic test_back_to_back();
        exp_t e; int n;
        issue(2'b10, 32'd1000, 32'hFFFF_FFFD, 1'b1);
        wait_done(n);
        take(e);
        checks++; if (lo !== e.lo) begin errors++; $display("FAIL b2b_first_lo: got %h expected %h", lo, e.lo); end
        issue(2'b00, 32'h0001_2345, 32'hFFF0_0001, 1'b1);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_accept: got busy %b expected 1", busy); end
        wait_done(n);
        take(e);
        checks++; if (n != 33)     begin errors++; $display("FAIL b2b_latency: got %0d expected 33", n); end
        checks++; if (hi !== e.hi) begin errors++; $display("FAIL b2b_second_hi: got %h expected %h", hi, e.hi); end
        checks++; if (lo !== e.lo) begin errors++; $display("FAIL b2b_second_lo: got %h expected %h", lo, e.lo); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_op();
        exp_t e; int n, dones;
        issue(2'b11, 32'd1000, 32'd3, 1'b1);
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        #1;
        exp_q.delete(); m_hi = '0; m_lo = '0;
        checks++; if (hi !== 32'd0)  begin errors++; $display("FAIL midreset_hi: got %h expected 0", hi); end
        checks++; if (lo !== 32'd0)  begin errors++; $display("FAIL midreset_lo: got %h expected 0", lo); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midreset_busy: got %b expected 0", busy); end
        @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done === 1'b1) dones++;
        end
        checks++; if (dones != 0) begin errors++; $display("FAIL midreset_done: got %0d pulses expected 0", dones); end
        issue(2'b01, 32'd6, 32'd7, 1'b1);
        wait_done(n);
        take(e);
        checks++; if (lo !== 32'd42) begin errors++; $display("FAIL post_reset_lo: got %h expected 0000002a", lo); end
        checks++; if (hi !== e.hi)   begin errors++; $display("FAIL post_reset_hi: got %h expected %h", hi, e.hi); end
        @(negedge clk);
    endtask

    task automatic test_random();
        exp_t e; int n;
        logic [1:0] o; logic [31:0] x, y;
        for (int i = 0; i < 12; i++) begin
            o = 2'($urandom_range(0, 3));
            x = $urandom;
            y = ($urandom_range(0, 7) == 0) ? 32'd0 : 32'($urandom >> $urandom_range(0, 28));
            issue(o, x, y, 1'b1);
            wait_done(n);
            take(e);
            checks++; if (n >= 100) begin errors++; $display("FAIL rand%0d_timeout: got %0d cycles expected 33", i, n); end
            checks++; if ({hi, lo} !== {e.hi, e.lo})
                begin errors++; $display("FAIL rand%0d op=%0d a=%h b=%h: got %h_%h expected %h_%h", i, o, x, y, hi, lo, e.hi, e.lo); end
`ifdef MUL_DIV_DIV0_FLAG_EN
            checks++; if (div0 !== e.dz) begin errors++; $display("FAIL rand%0d_div0: got %b expected %b", i, div0, e.dz); end
`endif
            if ($urandom_range(0, 1) == 1) @(negedge clk);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_multu_latency();
        test_directed();
        test_mthi_mtlo();
        test_back_to_back();
        test_reset_mid_op();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
